// File: rtl/pipe_ctrl.sv
// Y86-64 five-stage pipeline hazard/sequencing controller (load/use, mispredict, ret, halt).
// Optional PIPE_CTRL_STATS_EN adds saturating stall_cnt/bubble_cnt outputs.
module pipe_ctrl #(
    parameter logic [3:0] RNONE       = 4'hF,
    parameter int         RET_BUBBLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        W_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        halted
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_POPQ   = 4'd11;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [1:0] RET_INIT = 2'(RET_BUBBLES - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_RET  = 2'd1,
        ST_HALT = 2'd2
    } st_t;

    st_t        st_q, st_d;
    logic [1:0] ret_cnt_q, ret_cnt_d;
    logic       lu, mp, ex;

    assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mp = (E_icode == I_JXX) && !e_Cnd;
    assign ex = (m_stat != S_AOK) || (W_stat != S_AOK);

    always_comb begin
        st_d      = st_q;
        ret_cnt_d = ret_cnt_q;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        W_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        halted    = 1'b0;
        case (st_q)
            ST_RUN: begin
                if (ex) begin
                    M_bubble  = 1'b1;
                    W_stall   = (W_stat != S_AOK);
                    st_d      = ST_HALT;
                end else if (mp) begin
                    D_bubble  = 1'b1;
                    E_bubble  = 1'b1;
                end else if (lu) begin
                    F_stall   = 1'b1;
                    D_stall   = 1'b1;
                    E_bubble  = 1'b1;
                end else if (D_icode == I_RET) begin
                    F_stall   = 1'b1;
                    D_bubble  = 1'b1;
                    if (RET_BUBBLES > 1) begin
                        st_d      = ST_RET;
                        ret_cnt_d = RET_INIT;
                    end
                end
            end
            ST_RET: begin
                if (ex) begin
                    M_bubble  = 1'b1;
                    W_stall   = (W_stat != S_AOK);
                    st_d      = ST_HALT;
                    ret_cnt_d = 2'd0;
                end else begin
                    F_stall   = 1'b1;
                    D_bubble  = 1'b1;
                    ret_cnt_d = ret_cnt_q - 2'd1;
                    if (ret_cnt_q == 2'd1) begin
                        st_d = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                halted   = 1'b1;
            end
            default: begin
                st_d      = ST_RUN;
                ret_cnt_d = 2'd0;
            end
        endcase
        // Reset flushes the pipe with bubbles regardless of state.
        if (rst) begin
            F_stall  = 1'b0;
            D_stall  = 1'b0;
            W_stall  = 1'b0;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            halted   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= ST_RUN;
            ret_cnt_q <= 2'd0;
        end else begin
            st_q      <= st_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (st_q != ST_HALT) begin
            if (F_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if ((D_bubble || E_bubble) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
